// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the chunked subtract/add unit
//
// Contents:
//   state_t   control FSM states (IDLE, RUN, DONE)
//   MODE_ADD  mode encoding for A + B + Cin
//   MODE_SUB  mode encoding for A - B - Bin
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational CHUNK-bit ripple subtract/add slice
//
// Ports:
//   a, b   in   CHUNK  operand slices
//   cin    in   1      borrow-in (sub) / carry-in (add)
//   mode   in   1      MODE_SUB or MODE_ADD
//   d      out  CHUNK  result slice
//   cout   out  1      borrow-out (sub) / carry-out (add)
module sub_chunk
  import sub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [CHUNK-1:0] d,
  output logic             cout
);

  always_comb begin : ripple
    logic c;
    d = '0;
    c = cin;
    // Sum/difference bit is the same XOR in both modes; only the chain term differs.
    for (int i = 0; i < CHUNK; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_SUB) begin
        c = (~a[i] & b[i]) | ((~a[i] | b[i]) & c);
      end else begin
        c = (a[i] & b[i]) | ((a[i] | b[i]) & c);
      end
    end
    cout = c;
  end

endmodule

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle WIDTH-bit subtract/add, CHUNK bits per cycle
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      idle and able to accept
//   a          in   WIDTH  minuend / addend
//   b          in   WIDTH  subtrahend / addend
//   bin        in   1      borrow-in (sub) / carry-in (add)
//   mode       in   1      1 = subtract, 0 = add
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  result
//   bout       out  1      borrow-out / carry-out from MSB
//   ovf        out  1      signed overflow
//   zero       out  1      diff == 0
module chunked_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCYC = WIDTH / CHUNK;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("chunked_subtractor: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_n;
  logic             mode_q, br_q, bout_q, ovf_q, zero_q;
  logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
  logic             c_out, last, accept, ovf_n;

  assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
  assign last    = (cnt_q == CW'(NCYC - 1));
  assign accept  = (state_q == IDLE) && in_valid;

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (br_q),
    .mode (mode_q),
    .d    (d_chunk),
    .cout (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result with the current chunk merged in; flags on the final chunk use this
  // so they are registered in the same edge as the last result bits.
  always_comb begin
    diff_n = diff_q;
    diff_n[cnt_q*CHUNK +: CHUNK] = d_chunk;
  end

  always_comb begin
    if (mode_q == MODE_SUB) begin
      ovf_n = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_n[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf_n = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (diff_n[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      br_q   <= bin;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      diff_q <= diff_n;
      br_q   <= c_out;
      cnt_q  <= cnt_q + CW'(1);
      if (last) begin
        bout_q <= c_out;
        ovf_q  <= ovf_n;
        zero_q <= (diff_n == '0);
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - self-checking bench for chunked_subtractor
module tb_chunked_subtractor;
  import sub_pkg::*;

  localparam int W = 16;
  parameter int CHUNK = 4;
  localparam int NCYC = W / CHUNK;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         bin, mode, bout, ovf, zero;

  chunked_subtractor #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, input logic mmode);
    exp_t       r;
    logic [W:0] full;
    if (mmode == MODE_SUB) full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    else                   full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mbin};
    r.diff = full[W-1:0];
    r.bout = full[W];
    if (mmode == MODE_SUB) r.ovf = (ma[W-1] != mb[W-1]) && (r.diff[W-1] != ma[W-1]);
    else                   r.ovf = (ma[W-1] == mb[W-1]) && (r.diff[W-1] != ma[W-1]);
    r.zero = (r.diff == '0);
    return r;
  endfunction

  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic tmode);
    a        = ta;
    b        = tb;
    bin      = tbin;
    mode     = tmode;
    in_valid = 1'b1;
    sb.push_back(model(ta, tb, tbin, tmode));
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic finish_op(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < NCYC + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, NCYC);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_diff"}, diff, e.diff);
      chk({tag, "_bout"}, bout, e.bout);
      chk({tag, "_ovf"},  ovf,  e.ovf);
      chk({tag, "_zero"}, zero, e.zero);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"},  in_ready,  1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic tmode);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    drive_op(ta, tb, tbin, tmode);
    @(negedge clk);
    in_valid = 1'b0;
    finish_op(tag);
  endtask

  initial begin
    int   cyc;
    exp_t held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    mode      = MODE_SUB;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff",      diff,      0);
    chk("rst_bout",      bout,      0);
    chk("rst_ovf",       ovf,       0);
    chk("rst_zero",      zero,      0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed arithmetic cases
    run_op("t1_sub",      16'h0005, 16'h0003, 1'b0, MODE_SUB);
    run_op("t2_sub_wrap", 16'h0000, 16'h0001, 1'b0, MODE_SUB);
    run_op("t2_sub_ovf",  16'h8000, 16'h0001, 1'b0, MODE_SUB);
    run_op("t3_add_ovf",  16'h7FFF, 16'h0001, 1'b0, MODE_ADD);
    run_op("t3_add_cy",   16'hFFFF, 16'h0001, 1'b0, MODE_ADD);
    run_op("t_add_cin",   16'h1234, 16'h4321, 1'b1, MODE_ADD);

    // Backpressure in DONE with in_valid held high
    drive_op(16'h1111, 16'h0222, 1'b0, MODE_SUB);
    @(negedge clk);
    a    = 16'hAAAA;
    b    = 16'h5555;
    bin  = 1'b0;
    mode = MODE_ADD;
    cyc  = 0;
    while (!out_valid && cyc < NCYC + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_latency", cyc, NCYC);
    held = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_diff",  diff,      held.diff);
      chk("t4_hold_ready", in_ready,  0);
      @(negedge clk);
    end
    chk("t4_sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      held = sb.pop_front();
      chk("t4_diff", diff, held.diff);
      chk("t4_bout", bout, held.bout);
    end
    out_ready = 1'b1;
    sb.push_back(model(16'hAAAA, 16'h5555, 1'b0, MODE_ADD));
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_release_valid", out_valid, 0);
    chk("t4_release_ready", in_ready,  1);
    @(negedge clk);
    in_valid = 1'b0;
    finish_op("t4_new");

    // Reset during RUN with cnt == 2
    drive_op(16'h4321, 16'h0123, 1'b0, MODE_SUB);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_diff",  diff,      0);
    chk("t5_rst_ready", in_ready,  0);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("t5_after", 16'h1234, 16'h1233, 1'b1, MODE_SUB);

    // Random operations in both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 100; i++) begin
        run_op((m == 0) ? "rnd_add" : "rnd_sub", W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)), (m == 0) ? MODE_ADD : MODE_SUB);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
